overture_io_responder: RTL and testbench
========================================

// Module: overture_io_responder
// PURPOSE
//  Host-side responder for the Overture CPU I/O register (reg 6).
//  - Snoops the executing instruction and feeds input bytes to the CPU from an input FIFO.
//  - Captures CPU output writes into an output FIFO.
//  - Gates the CPU run enable when the program would read an empty input or write a full output.
//  - Sits between the program wrappers (clk/reset/run/in_port/out_port/instr_debug) and a testbench or host stream.
// PARAMETERS
//  IN_DEPTH   8   input FIFO depth, bytes (power of 2, >=2)
//  OUT_DEPTH  8   output FIFO depth, bytes (power of 2, >=2)
//  CNT_W      16  width of the transfer counters
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset_n       in   1      asynchronous active-low reset
//  run_req       in   1      host wants the CPU to execute this cycle
//  cpu_run       out  1      run enable to CPU = run_req & ~stalled & reset_n
//  cpu_instr     in   8      CPU instr_debug (instruction at current pc)
//  cpu_out_port  in   8      CPU out_port register
//  cpu_in_port   out  8      byte presented to CPU in_port
//  in_data       in   8      host input byte
//  in_valid      in   1      host input byte valid
//  in_ready      out  1      input FIFO not full
//  out_data      out  8      captured CPU output byte (FIFO head)
//  out_valid     out  1      output FIFO not empty
//  out_ready     in   1      host accepts out_data
//  stalled       out  1      current instruction blocked on I/O
//  in_consumed   out  CNT_W  bytes read by CPU since reset
//  out_produced  out  CNT_W  bytes written by CPU since reset
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - FIFOs empty; pend_out=0; counters=0.
//   - cpu_run=0, in_ready=0, out_valid=0, stalled=0, cpu_in_port=8'h00.
//   - in_ready rises the first cycle after release.
//  Decode (combinational, from cpu_instr):
//   - is_rd = instr[7:6]==2'b10 && instr[5:3]==3'd6
//   - is_wr = instr[7:6]==2'b10 && instr[2:0]==3'd6
//   - 8'hB6 is both a read and a write.
//  Stall:
//   - stalled = run_req & ((is_rd & in_empty) | (is_wr & out_full_eff)).
//   - out_full_eff = (out_count + pend_out) == OUT_DEPTH.
//   - Stall is held until the condition clears; the CPU pc does not advance.
//  Input path:
//   - cpu_in_port = input FIFO head, or 8'h00 when empty.
//   - Fire edge: cpu_run & is_rd. On that edge the head is popped and in_consumed increments.
//   - Push when in_valid & in_ready.
//   - Push and pop in the same cycle are both honoured.
//   - No bypass: a byte pushed into an empty FIFO is visible one cycle later.
//  Output path:
//   - The CPU updates out_port on the fire edge (cpu_run & is_wr), which sets pend_out=1.
//   - Next cycle: push cpu_out_port, clear pend_out, increment out_produced.
//   - Back-to-back writes are legal: pend_out stays 1 and each cycle pushes one byte.
//   - Latency, write-instruction edge to out_valid: 2 cycles.
//   - Pop when out_valid & out_ready. Simultaneous push and pop is allowed.
//  Counters wrap modulo 2^CNT_W.
//  run_req=0: no fire, no stall; pending capture still completes.
//  Reset mid-transfer discards pend_out and all FIFO contents.
// STRUCTURE
//  - overture_pkg:
//    - OPC_COPY=2'b10, REG_IO=3'd6
//    - functions is_io_read(instr), is_io_write(instr)
//  - Sub-module overture_byte_fifo #(DEPTH):
//    - ports push/pop/full/empty/count/head
//    - instantiated twice (input and output)
//  - Top holds decode, stall logic, pend_out flop and counters.
// TESTING
//  1. Reset: reset_n=0 mid-stream -> all outputs at reset values; counters 0; FIFOs empty after release.
//  2. Input read: push 8'h2A; instr=8'hB0 (in->r0), run_req=1
//     -> cpu_in_port=8'h2A, cpu_run=1, in_consumed=1, FIFO empty next cycle.
//  3. Empty stall: instr=8'hB0, FIFO empty -> stalled=1, cpu_run=0.
//     Push 8'h05 -> fire one cycle after the push edge.
//  4. Output capture: instr=8'h86 (r0->out), cpu_out_port=8'h7F
//     -> out_valid 2 cycles later, out_data=8'h7F, out_produced=1.
//  5. Full stall: OUT_DEPTH writes with out_ready=0 -> next 8'h86 gives stalled=1;
//     one pop -> exactly one more write fires.
//  6. Passthrough: instr=8'hB6, 3 bytes 01,02,03 with out_ready=1
//     -> out_data stream 01,02,03; in_consumed=out_produced=3.

Source files
------------

// File: rtl/overture_pkg.sv
// Shared constants and instruction decode helpers for the Overture I/O responder.
package overture_pkg;

    // COPY opcode field (instr[7:6]) and the register index of the I/O port.
    localparam logic [1:0] OPC_COPY = 2'b10;
    localparam logic [2:0] REG_IO   = 3'd6;

    // A COPY whose source register is the I/O port reads one input byte.
    function automatic logic is_io_read(input logic [7:0] instr);
        return (instr[7:6] == OPC_COPY) && (instr[5:3] == REG_IO);
    endfunction

    // A COPY whose destination register is the I/O port writes one output byte.
    function automatic logic is_io_write(input logic [7:0] instr);
        return (instr[7:6] == OPC_COPY) && (instr[2:0] == REG_IO);
    endfunction

endpackage

// File: rtl/overture_byte_fifo.sv
// Byte-wide synchronous FIFO with registered storage and no write-to-read bypass.
// A push into an empty FIFO becomes visible at the head one cycle later.
// Push while full and pop while empty are ignored; push and pop together are both honoured.
module overture_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/overture_io_responder.sv
// Host-side responder for the Overture CPU I/O register: feeds input bytes to the
// CPU, captures its output writes, and withholds run enable while an I/O
// instruction cannot complete.
//
// Host streams use valid/ready: a byte transfers on a rising edge where both
// valid and ready are high; valid never depends on ready.
module overture_io_responder
    import overture_pkg::*;
#(
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run_req,
    output logic             cpu_run,
    input  logic [7:0]       cpu_instr,
    input  logic [7:0]       cpu_out_port,
    output logic [7:0]       cpu_in_port,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             stalled,
    output logic [CNT_W-1:0] in_consumed,
    output logic [CNT_W-1:0] out_produced
);
    localparam int ICW = $clog2(IN_DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;
    localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_DEPTH - 1);

    logic           is_rd;
    logic           is_wr;
    logic           in_full;
    logic           in_empty;
    logic [ICW-1:0] in_count;
    logic [7:0]     in_head;
    logic           out_full;
    logic           out_empty;
    logic [OCW-1:0] out_count;
    logic           out_full_eff;
    logic           pend_out;
    logic           alive;
    logic           fire_rd;
    logic           fire_wr;
    logic           in_push;
    logic           out_pop;

    assign is_rd = is_io_read(cpu_instr);
    assign is_wr = is_io_write(cpu_instr);

    // A byte already committed by the CPU (pend_out) occupies a slot even before it lands.
    assign out_full_eff = out_full | (pend_out & (out_count == OUT_LAST));

    // Stall and run enable; reset_n gating keeps both low while reset is asserted.
    always_comb begin
        stalled = 1'b0;
        cpu_run = 1'b0;
        if (reset_n && run_req) begin
            stalled = (is_rd & in_empty) | (is_wr & out_full_eff);
            cpu_run = ~stalled;
        end
    end

    assign fire_rd = cpu_run & is_rd;
    assign fire_wr = cpu_run & is_wr;

    // alive holds in_ready low until the first edge after reset release.
    assign in_ready    = alive & ~in_full;
    assign in_push     = in_valid & in_ready;
    assign cpu_in_port = (in_count != '0) ? in_head : 8'h00;
    assign out_valid   = ~out_empty;
    assign out_pop     = out_valid & out_ready;

    overture_byte_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_push),
        .push_data (in_data),
        .pop       (fire_rd),
        .head      (in_head),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    // The CPU's out_port only holds the written byte after the fire edge, so it is pushed one cycle later.
    overture_byte_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pend_out),
        .push_data (cpu_out_port),
        .pop       (out_pop),
        .head      (out_data),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    // Pending-capture flag, post-reset enable and wrapping transfer counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive        <= 1'b0;
            pend_out     <= 1'b0;
            in_consumed  <= '0;
            out_produced <= '0;
        end else begin
            alive    <= 1'b1;
            pend_out <= fire_wr;
            if (fire_rd) begin
                in_consumed <= in_consumed + 1'b1;
            end
            if (pend_out) begin
                out_produced <= out_produced + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_overture_io_responder.sv
// Directed bench for overture_io_responder: reset, input read, empty stall,
// output capture, full stall, mid-stream reset and read/write passthrough.
module tb_overture_io_responder;

    logic        clk;
    logic        reset_n;
    logic        run_req;
    logic        cpu_run;
    logic [7:0]  cpu_instr;
    logic [7:0]  cpu_out_port;
    logic [7:0]  cpu_in_port;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        stalled;
    logic [15:0] in_consumed;
    logic [15:0] out_produced;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    overture_io_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run_req      (run_req),
        .cpu_run      (cpu_run),
        .cpu_instr    (cpu_instr),
        .cpu_out_port (cpu_out_port),
        .cpu_in_port  (cpu_in_port),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .stalled      (stalled),
        .in_consumed  (in_consumed),
        .out_produced (out_produced)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run_req = 1'b1; cpu_instr = 8'hB0; cpu_out_port = 8'h00;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        #3;
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL rst_cpu_run actual=%0h required=0", cpu_run); end
        checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL rst_stalled actual=%0h required=0", stalled); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready actual=%0h required=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid actual=%0h required=0", out_valid); end
        checks++; if (cpu_in_port !== 8'h00) begin failures++; $display("FAIL rst_in_port actual=%0h required=00", cpu_in_port); end
        checks++; if (in_consumed !== 16'd0 || out_produced !== 16'd0) begin failures++; $display("FAIL rst_counters actual=%0d/%0d required=0/0", in_consumed, out_produced); end
        run_req = 1'b0; cpu_instr = 8'h00;
        step(); step();
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rel_in_ready_early actual=%0h required=0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready actual=%0h required=1", in_ready); end
    endtask

    task automatic test_input_read();
        in_data = 8'h2A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cpu_instr = 8'hB0; run_req = 1'b1;
        #1;
        checks++; if (cpu_in_port !== 8'h2A) begin failures++; $display("FAIL rd_in_port actual=%0h required=2a", cpu_in_port); end
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL rd_cpu_run actual=%0h required=1", cpu_run); end
        step();
        run_req = 1'b0;
        #1;
        checks++; if (in_consumed !== 16'd1) begin failures++; $display("FAIL rd_consumed actual=%0d required=1", in_consumed); end
        checks++; if (cpu_in_port !== 8'h00) begin failures++; $display("FAIL rd_empty_port actual=%0h required=00", cpu_in_port); end
    endtask

    task automatic test_empty_stall();
        cpu_instr = 8'hB0; run_req = 1'b1;
        #1;
        checks++; if (stalled !== 1'b1 || cpu_run !== 1'b0) begin failures++; $display("FAIL es_stall actual=%0h/%0h required=1/0", stalled, cpu_run); end
        in_data = 8'h05; in_valid = 1'b1;
        #1;
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL es_no_bypass actual=%0h required=1", stalled); end
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (stalled !== 1'b0 || cpu_run !== 1'b1) begin failures++; $display("FAIL es_release actual=%0h/%0h required=0/1", stalled, cpu_run); end
        checks++; if (cpu_in_port !== 8'h05) begin failures++; $display("FAIL es_in_port actual=%0h required=05", cpu_in_port); end
        step();
        run_req = 1'b0;
        #1;
        checks++; if (in_consumed !== 16'd2) begin failures++; $display("FAIL es_consumed actual=%0d required=2", in_consumed); end
    endtask

    task automatic test_output_capture();
        out_ready = 1'b0; cpu_instr = 8'h86; cpu_out_port = 8'h7F; run_req = 1'b1;
        #1;
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL oc_cpu_run actual=%0h required=1", cpu_run); end
        step();
        run_req = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL oc_valid_early actual=%0h required=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h7F) begin failures++; $display("FAIL oc_data actual=%0h/%0h required=1/7f", out_valid, out_data); end
        checks++; if (out_produced !== 16'd1) begin failures++; $display("FAIL oc_produced actual=%0d required=1", out_produced); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL oc_pop actual=%0h required=0", out_valid); end
    endtask

    task automatic test_full_stall();
        int cyc;
        out_ready = 1'b0; cpu_instr = 8'h86; run_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL fs_fire%0d actual=%0h required=1", i, cpu_run); end
            step();
            cpu_out_port = 8'h10 + 8'(i);
        end
        #1;
        checks++; if (stalled !== 1'b1 || cpu_run !== 1'b0) begin failures++; $display("FAIL fs_stall_pend actual=%0h/%0h required=1/0", stalled, cpu_run); end
        step();
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL fs_stall_full actual=%0h required=1", stalled); end
        checks++; if (out_produced !== 16'd9) begin failures++; $display("FAIL fs_produced actual=%0d required=9", out_produced); end
        checks++; if (out_data !== 8'h10) begin failures++; $display("FAIL fs_head actual=%0h required=10", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL fs_one_more actual=%0h required=1", cpu_run); end
        step();
        cpu_out_port = 8'h18;
        #1;
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL fs_restall actual=%0h required=1", stalled); end
        run_req = 1'b0;
        step();
        checks++; if (out_produced !== 16'd10) begin failures++; $display("FAIL fs_produced2 actual=%0d required=10", out_produced); end
        exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'h10 + 8'(i));
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            if (out_valid === 1'b1) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++; if (out_data !== e) begin failures++; $display("FAIL fs_drain actual=%0h required=%0h", out_data, e); end
            end
            step();
            cyc++;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fs_drain_timeout actual=%0d required=0 left", exp_q.size()); end
        out_ready = 1'b0;
    endtask

    task automatic test_midstream_reset();
        in_data = 8'hAA; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cpu_instr = 8'h86; cpu_out_port = 8'h55; run_req = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (cpu_run !== 1'b0 || stalled !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mr_ctrl actual=%0h/%0h/%0h required=0/0/0", cpu_run, stalled, in_ready); end
        checks++; if (out_valid !== 1'b0 || cpu_in_port !== 8'h00) begin failures++; $display("FAIL mr_data actual=%0h/%0h required=0/00", out_valid, cpu_in_port); end
        checks++; if (in_consumed !== 16'd0 || out_produced !== 16'd0) begin failures++; $display("FAIL mr_counters actual=%0d/%0d required=0/0", in_consumed, out_produced); end
        run_req = 1'b0;
        step();
        reset_n = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0 || out_produced !== 16'd0) begin failures++; $display("FAIL mr_pend_discard actual=%0h/%0d required=0/0", out_valid, out_produced); end
        checks++; if (in_ready !== 1'b1 || cpu_in_port !== 8'h00) begin failures++; $display("FAIL mr_after actual=%0h/%0h required=1/00", in_ready, cpu_in_port); end
    endtask

    task automatic test_passthrough();
        int cyc;
        int fires;
        int got;
        logic       fire_now;
        logic [7:0] v;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        cpu_instr = 8'hB6; run_req = 1'b1;
        #1;
        fires = 0; got = 0; cyc = 0;
        while (got < 3 && cyc < 30) begin
            fire_now = cpu_run;
            v = cpu_in_port;
            if (out_valid === 1'b1) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                got++;
                checks++; if (out_data !== e) begin failures++; $display("FAIL pt_data actual=%0h required=%0h", out_data, e); end
            end
            step();
            if (fire_now) begin
                cpu_out_port = v;
                fires++;
                if (fires == 3) run_req = 1'b0;
            end
            cyc++;
        end
        checks++; if (got != 3) begin failures++; $display("FAIL pt_timeout actual=%0d required=3 bytes", got); end
        step();
        checks++; if (in_consumed !== 16'd3 || out_produced !== 16'd3) begin failures++; $display("FAIL pt_counters actual=%0d/%0d required=3/3", in_consumed, out_produced); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pt_drained actual=%0h required=0", out_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_input_read();
        test_empty_stall();
        test_output_capture();
        test_full_stall();
        test_midstream_reset();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
